// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive controller.
// Synchronises the serial line and validates the start bit at mid-bit.
// Samples data, parity and stop bits at each bit centre.
// Hands the assembled word to the host over valid/ready, with parity,
// framing and overrun flags.
module uart_rx_ctrl #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic                 shift,
    output logic                 parity_check,
    output logic                 chk_stop,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          PAR_EN    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 pbad_q, pbad_d;
    logic                 shift_q, shift_d;
    logic                 par_chk_q, par_chk_d;
    logic                 chk_stop_q, chk_stop_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 done;
    logic                 accept;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state, strobe and handshake logic; only baud ticks advance the frame.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        armed_d      = armed_q;
        shreg_d      = shreg_q;
        pbad_d       = pbad_q;
        shift_d      = 1'b0;
        par_chk_d    = 1'b0;
        chk_stop_d   = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = overrun_q;
        done         = 1'b0;
        accept       = rx_valid_q && rx_ready;

        if (baud_tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    tick_cnt_d = '0;
                    if (rx_s_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = S_START;
                        armed_d = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = 1'b1;
                        shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = PAR_EN ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_chk_d  = 1'b1;
                        pbad_d     = (^shreg_q) ^ rx_s_q ^ PAR_ODD;
                        state_d    = S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        chk_stop_d = 1'b1;
                        state_d    = S_IDLE;
                        // A low stop bit keeps the detector disarmed through a break.
                        armed_d    = rx_s_q;
                        done       = 1'b1;
                    end
                end
                default: begin
                    tick_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            endcase
        end

        if (accept) begin
            rx_valid_d   = 1'b0;
            overrun_d    = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
        end

        // A completing word wins over an accept in the same cycle.
        if (done) begin
            rx_data_d    = shreg_q;
            parity_err_d = PAR_EN & pbad_q;
            frame_err_d  = ~rx_s_q;
            rx_valid_d   = 1'b1;
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // Frame state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            armed_q      <= 1'b0;
            shreg_q      <= '0;
            pbad_q       <= 1'b0;
            shift_q      <= 1'b0;
            par_chk_q    <= 1'b0;
            chk_stop_q   <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            armed_q      <= armed_d;
            shreg_q      <= shreg_d;
            pbad_q       <= pbad_d;
            shift_q      <= shift_d;
            par_chk_q    <= par_chk_d;
            chk_stop_q   <= chk_stop_d;
            busy_q       <= busy_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign shift        = shift_q;
    assign parity_check = par_chk_q;
    assign chk_stop     = chk_stop_q;
    assign busy         = busy_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;
    assign overrun_err  = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected words are queued as frames are
// driven and compared when chk_stop fires.
module tb_uart_rx_ctrl;

    localparam int OS        = 16;
    localparam int DB        = 8;
    localparam int PE        = 1;
    localparam int PO        = 0;
    localparam int STOP_TICK = OS / 2 + OS * (DB + PE + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          baud_tick;
    logic          rx_in;
    logic          rx_ready;
    logic          shift, parity_check, chk_stop, busy;
    logic [DB-1:0] rx_data;
    logic          rx_valid, parity_err, frame_err, overrun_err;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors    = 0;
    int   checks    = 0;
    int   gap       = 2;
    int   tick_no   = 0;
    int   last_tick = 0;
    int   t0        = 0;
    int   n_shift   = 0;
    int   n_par     = 0;
    int   n_stop    = 0;
    int   snap_shift, snap_stop;

    uart_rx_ctrl #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .PARITY_EN  (PE),
        .PARITY_ODD (PO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .rx_in        (rx_in),
        .shift        (shift),
        .parity_check (parity_check),
        .chk_stop     (chk_stop),
        .busy         (busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t x;
        x.data = d;
        x.perr = p;
        x.ferr = f;
        x.ovr  = o;
        exp_q.push_back(x);
    endtask

    // One baud tick; with gap>=2 the synchronised line equals rx at the tick.
    task automatic do_tick(input logic rx, input logic rdy);
        rx_in = rx;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        baud_tick = 1'b1;
        rx_ready  = rdy;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
        rx_ready  = 1'b0;
        last_tick = tick_no;
        tick_no++;
    endtask

    task automatic send_bit(input logic v, input logic rdy_mid);
        for (int j = 0; j < OS; j++) do_tick(v, rdy_mid && (j == OS / 2));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopb,
                              input logic rdy_stop);
        logic pb;
        pb = (^d) ^ (PO != 0) ^ pflip;
        for (int i = 0; i < 4; i++) do_tick(1'b1, 1'b0);
        t0 = tick_no;
        send_bit(1'b0, 1'b0);
        for (int k = 0; k < DB; k++) send_bit(d[k], 1'b0);
        if (PE != 0) send_bit(pb, 1'b0);
        send_bit(stopb, rdy_stop);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    // Scoreboard monitor: strobe counts, stop timing and the delivered word.
    always @(negedge clk) begin
        if (!reset) begin
            n_shift = 0;
            n_par   = 0;
        end else begin
            if (shift) n_shift++;
            if (parity_check) n_par++;
            if (chk_stop) begin
                n_stop++;
                check("shift_count", n_shift, DB);
                check("parity_strobes", n_par, PE);
                if (gap == 2) check("stop_tick", last_tick - t0, STOP_TICK);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_valid", rx_valid, 1);
                    check("rx_data", rx_data, e.data);
                    check("parity_err", parity_err, e.perr);
                    check("frame_err", frame_err, e.ferr);
                    check("overrun_err", overrun_err, e.ovr);
                end
                n_shift = 0;
                n_par   = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        baud_tick = 1'b0;
        rx_in     = 1'b1;
        rx_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_flags", {parity_err, frame_err, overrun_err}, 0);
        check("rst_strobes", {shift, parity_check, chk_stop}, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Clean 0xA5 frame, consumer not ready.
        gap = 2;
        push_exp(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_hold_valid", rx_valid, 1);
        check("a5_busy_low", busy, 0);
        accept();
        check("a5_accept_valid", rx_valid, 0);

        // False start with back-to-back ticks, then a good frame.
        gap        = 0;
        snap_shift = n_shift;
        snap_stop  = n_stop;
        for (int i = 0; i < 4; i++) do_tick(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b0);
        check("fs_busy_high", busy, 1);
        for (int i = 0; i < 20; i++) do_tick(1'b1, 1'b0);
        check("fs_busy_low", busy, 0);
        check("fs_no_shift", n_shift - snap_shift, 0);
        check("fs_no_stop", n_stop - snap_stop, 0);
        check("fs_no_valid", rx_valid, 0);
        push_exp(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        accept();

        // Parity error on 0x01 sent with parity bit 0.
        gap = 1;
        push_exp(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        check("par_err_held", parity_err, 1);
        accept();
        check("par_valid_clr", rx_valid, 0);
        check("par_err_clr", parity_err, 0);

        // Framing error followed by a long break.
        gap = 0;
        push_exp(8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        accept();
        check("brk_ferr_clr", frame_err, 0);
        snap_stop  = n_stop;
        snap_shift = n_shift;
        for (int i = 0; i < 200; i++) do_tick(1'b0, 1'b0);
        check("brk_no_frame", n_stop - snap_stop, 0);
        check("brk_no_shift", n_shift - snap_shift, 0);
        check("brk_busy", busy, 0);
        for (int i = 0; i < 8; i++) do_tick(1'b1, 1'b0);
        push_exp(8'h12, 1'b0, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        accept();

        // Overrun, then completion and accept in the same cycle.
        gap = 2;
        push_exp(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        accept();
        check("ovr_valid_clr", rx_valid, 0);
        check("ovr_flags_clr", {parity_err, frame_err, overrun_err}, 0);
        push_exp(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        push_exp(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check("same_cyc_valid", rx_valid, 1);
        check("same_cyc_ovr", overrun_err, 0);
        check("same_cyc_data", rx_data, 8'h22);
        accept();

        // Reset in the middle of data bit 4 with a word still pending.
        push_exp(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_tick(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_bit(k[0], 1'b0);
        for (int i = 0; i < OS / 2; i++) do_tick(1'b1, 1'b0);
        check("mid_busy", busy, 1);
        check("mid_valid", rx_valid, 1);
        reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", rx_valid, 0);
        check("arst_data", rx_data, 0);
        check("arst_flags", {parity_err, frame_err, overrun_err}, 0);
        check("arst_strobes", {shift, parity_check, chk_stop}, 0);
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_exp(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        check("f0_data", rx_data, 8'hF0);
        check("f0_flags", {parity_err, frame_err, overrun_err}, 0);
        accept();

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
